leg_call_stack: RTL
===================

LEG_CALL_STACK -- requirements
Module: leg_call_stack

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, program-counter / return-address width in bits (≥4).
REQ-002 SHALL have parameter DEPTH, default 16, number of return-address entries (power of two, 2..256).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port call  input  1  push request: store call_addr as new top.
REQ-006 SHALL have port call_addr  input  ADDR_WIDTH  return address to push (caller PC + 4).
REQ-007 SHALL have port ret  input  1  pop request: discard current top.
REQ-008 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-009 SHALL have port ret_addr  output  ADDR_WIDTH  current top entry, combinational; 0 when empty.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-011 SHALL have ports full / empty  output  1 each  count==DEPTH / count==0.
REQ-012 SHALL have ports ovf_err / unf_err  output  1 each  sticky overflow / underflow flags.

Function
REQ-013 SHALL keep stack pointer sp (index of next free slot, modulo DEPTH) and count; top = sp-1 modulo DEPTH.
REQ-014 call only, not full: write call_addr at sp; sp+1; count+1; new top visible on ret_addr the cycle after the edge.
REQ-015 ret only, not empty: sp-1; count-1; ret_addr before the edge is the popped value (zero-latency read for the PC mux).
REQ-016 call and ret same cycle, not empty: top entry overwritten with call_addr; sp and count unchanged (tail-call semantics).
REQ-017 call and ret same cycle while empty: treated as call only; unf_err NOT set.
REQ-018 ret while empty: no state change; unf_err set next cycle; ret_addr stays 0.
REQ-019 call while full: behaviour per REQ-026/027; ovf_err set next cycle in both builds.
REQ-020 clr_err clears both flags next cycle; a new error in the same cycle as clr_err wins (flag set).
REQ-021 count SHALL never exceed DEPTH nor go below 0; sp wraps DEPTH-1→0 and 0→DEPTH-1.
REQ-022 No other inputs affect state; call/ret have no handshake, each asserted cycle is one operation.

Reset
REQ-023 While rst is high at a rising edge: sp=0, count=0, ovf_err=0, unf_err=0; rst dominates call/ret/clr_err.
REQ-024 After reset: ret_addr=0, empty=1, full=0; entry storage is not cleared.
REQ-025 Reset asserted mid-sequence discards all entries; first post-reset ret is an underflow.

Configuration
REQ-026 With LEG_CALL_STACK_WRAP_EN defined: call while full overwrites the oldest entry (write at sp, sp+1), count stays DEPTH, top = call_addr.
REQ-027 Without LEG_CALL_STACK_WRAP_EN: call while full is dropped; sp, count, entries unchanged.

Structure
REQ-028 Package leg_pkg SHALL hold LEG_ADDR_WIDTH default constant and the CALL/RET opcode constants shared with the core decoder.
REQ-029 Storage SHALL be sub-module leg_stack_ram: DEPTH x ADDR_WIDTH, synchronous write, asynchronous read, no reset.

Verification
REQ-030 Reset, then ret → ret_addr=0, unf_err=1 next cycle, count=0; clr_err → unf_err=0.
REQ-031 DEPTH=16: call 0x04,0x08,0x0C → count=3, ret_addr=0x0C; three rets read 0x0C,0x08,0x04; empty=1.
REQ-032 call 0x10, then call+ret with 0x20 → count=1, ret_addr=0x20.
REQ-033 16 calls 0x01..0x10, then call 0x11 → full=1, ovf_err=1; WRAP_EN: ret_addr=0x11, 16 pops end at 0x02; no WRAP_EN: ret_addr=0x10, pops end at 0x01.
REQ-034 Push 5 entries, assert rst with call=1 → count=0, empty=1, no push recorded.
REQ-035 Same-cycle clr_err and ret-on-empty → unf_err=1.

Source files
------------

// File: rtl/leg_pkg.sv
// Shared constants for the LEG core: default PC width, CALL/RET opcodes and
// the call-stack operation decode used by leg_call_stack.
package leg_pkg;

    localparam int LEG_ADDR_WIDTH = 8;

    // Opcodes the core decoder turns into call/ret strobes.
    localparam logic [3:0] LEG_OPC_CALL = 4'hE;
    localparam logic [3:0] LEG_OPC_RET  = 4'hF;

    typedef enum logic [2:0] {
        STK_IDLE,
        STK_PUSH,
        STK_POP,
        STK_SWAP,
        STK_OVF,
        STK_UNF
    } stk_op_e;

    // A simultaneous call+ret on an empty stack is a plain push (never an
    // underflow); on a non-empty stack it replaces the top (tail call).
    function automatic stk_op_e stk_decode(input logic call, input logic ret,
                                           input logic empty, input logic full);
        if (call && ret) return empty ? STK_PUSH : STK_SWAP;
        if (call)        return full  ? STK_OVF  : STK_PUSH;
        if (ret)         return empty ? STK_UNF  : STK_POP;
        return STK_IDLE;
    endfunction

endpackage

// File: rtl/leg_stack_ram.sv
// Return-address storage: DEPTH x ADDR_WIDTH, synchronous write, asynchronous
// read so the top entry feeds the PC mux with zero latency.
module leg_stack_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ADDR_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ADDR_WIDTH-1:0]    rdata
);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; validity is tracked by the
    // pointer/count in the parent, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/leg_call_stack.sv
// Hardware return-address stack with sticky overflow/underflow flags.
// Define LEG_CALL_STACK_WRAP_EN to overwrite the oldest entry on overflow.
module leg_call_stack
    import leg_pkg::*;
#(
    parameter int ADDR_WIDTH = LEG_ADDR_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   call,
    input  logic [ADDR_WIDTH-1:0]  call_addr,
    input  logic                   ret,
    input  logic                   clr_err,
    output logic [ADDR_WIDTH-1:0]  ret_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   ovf_err,
    output logic                   unf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         sp;
    logic [PW-1:0]         top;
    logic [PW-1:0]         wr_ptr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] rd_data;
    stk_op_e               op;

    // DEPTH is a power of two, so plain PW-bit arithmetic wraps the pointer.
    assign top   = sp - PW'(1);
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign op    = stk_decode(call, ret, empty, full);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        wr_en  = 1'b0;
        wr_ptr = sp;
        case (op)
            STK_PUSH: wr_en = 1'b1;
            STK_SWAP: begin
                wr_en  = 1'b1;
                wr_ptr = top;
            end
`ifdef LEG_CALL_STACK_WRAP_EN
            STK_OVF:  wr_en = 1'b1;
`endif
            default:  ;
        endcase
        if (rst) wr_en = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp      <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            case (op)
                STK_PUSH: begin
                    sp    <= sp + PW'(1);
                    count <= count + CW'(1);
                end
                STK_POP: begin
                    sp    <= top;
                    count <= count - CW'(1);
                end
`ifdef LEG_CALL_STACK_WRAP_EN
                STK_OVF:  sp <= sp + PW'(1);
`endif
                default:  ;
            endcase
            // A new error in the same cycle as clr_err keeps the flag set.
            ovf_err <= (op == STK_OVF) | (ovf_err & ~clr_err);
            unf_err <= (op == STK_UNF) | (unf_err & ~clr_err);
        end
    end

    leg_stack_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr),
        .wdata(call_addr),
        .raddr(top),
        .rdata(rd_data)
    );

    assign ret_addr = empty ? '0 : rd_data;

endmodule
